// File: rtl/writeback_stage.sv
// Writeback pipeline stage: W-stage register, result select, and the syscall
// controller that drives console requests and the exit halt.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] RD,
  input  logic [4:0]  WriteRegM,
  input  logic        StallW,
  input  logic        FlushW,
  input  logic [31:0] v0_in,
  input  logic [31:0] a0_in,
  input  logic        sys_ready,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        sys_valid,
  output logic [31:0] sys_code,
  output logic [31:0] sys_arg,
  output logic        syscall_busy,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYS_REQ = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [31:0] EXIT_CODE = 32'd10;

  state_t      state;
  state_t      state_next;
  logic        capture;
  logic        handshake;

  logic        syscall_w;
  logic        reg_write_r;
  logic        mem_to_reg_w;
  logic [31:0] alu_out_w;
  logic [31:0] read_data_w;

  assign handshake = (state == SYS_REQ) && sys_ready;

  // NOTE: every signal driven here gets a default first so no path can imply a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (syscall_w) begin
          if (v0_in == EXIT_CODE) begin
            state_next = HALT;
          end else begin
            state_next = SYS_REQ;
            capture    = 1'b1;
          end
        end
      end
      SYS_REQ: if (sys_ready) state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sys_code <= '0;
      sys_arg  <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        sys_code <= v0_in;
        sys_arg  <= a0_in;
      end
    end
  end

  // Priority: halt freeze, then flush or handshake bubble, then hold, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syscall_w    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      alu_out_w    <= '0;
      read_data_w  <= '0;
      WriteRegW    <= '0;
    end else if (state != HALT) begin
      if (FlushW || handshake) begin
        syscall_w   <= 1'b0;
        reg_write_r <= 1'b0;
      end else if (!(StallW || syscall_busy)) begin
        syscall_w    <= syscall;
        reg_write_r  <= RegWriteM;
        mem_to_reg_w <= MemtoRegM;
        alu_out_w    <= ALUOutM;
        read_data_w  <= RD;
        WriteRegW    <= WriteRegM;
      end
    end
  end

  assign ResultW      = mem_to_reg_w ? read_data_w : alu_out_w;
  assign RegWriteW    = reg_write_r && (state != HALT);
  assign sys_valid    = (state == SYS_REQ);
  assign halted       = (state == HALT);
  assign syscall_busy = (state != IDLE) || syscall_w;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues cycle-tagged expected
// outputs, a negedge monitor pops and compares them.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall, RegWriteM, MemtoRegM;
  logic [31:0] ALUOutM, RD;
  logic [4:0]  WriteRegM;
  logic        StallW, FlushW;
  logic [31:0] v0_in, a0_in;
  logic        sys_ready;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        sys_valid;
  logic [31:0] sys_code, sys_arg;
  logic        syscall_busy, halted;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .ALUOutM(ALUOutM), .RD(RD), .WriteRegM(WriteRegM),
    .StallW(StallW), .FlushW(FlushW), .v0_in(v0_in), .a0_in(a0_in),
    .sys_ready(sys_ready), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .sys_valid(sys_valid), .sys_code(sys_code),
    .sys_arg(sys_arg), .syscall_busy(syscall_busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    bit          is_sys;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        valid;
    logic [31:0] code;
    logic [31:0] arg;
    logic        busy;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every entry tagged for the cycle just completed.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check({e.name, "_missed"}, 32'(e.cyc), 32'(cyc));
      end else if (e.is_sys) begin
        check({e.name, "_valid"},  32'(sys_valid),    32'(e.valid));
        check({e.name, "_code"},   sys_code,          e.code);
        check({e.name, "_arg"},    sys_arg,           e.arg);
        check({e.name, "_busy"},   32'(syscall_busy), 32'(e.busy));
        check({e.name, "_halted"}, 32'(halted),       32'(e.halt));
      end else begin
        check({e.name, "_regwrite"}, 32'(RegWriteW), 32'(e.rw));
        check({e.name, "_writereg"}, 32'(WriteRegW), 32'(e.wr));
        check({e.name, "_result"},   ResultW,        e.res);
      end
    end
  end

  task automatic exp_wb(input string n, input logic rw, input logic [4:0] wr, input logic [31:0] res);
    exp_t e;
    e = '{cyc: cyc + 1, name: n, is_sys: 1'b0, rw: rw, wr: wr, res: res,
          valid: 1'b0, code: 32'h0, arg: 32'h0, busy: 1'b0, halt: 1'b0};
    sb.push_back(e);
  endtask

  task automatic exp_sys(input string n, input logic v, input logic [31:0] code,
                         input logic [31:0] arg, input logic busy, input logic halt);
    exp_t e;
    e = '{cyc: cyc + 1, name: n, is_sys: 1'b1, rw: 1'b0, wr: 5'd0, res: 32'h0,
          valid: v, code: code, arg: arg, busy: busy, halt: halt};
    sb.push_back(e);
  endtask

  task automatic drive_m(input logic sc, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
    syscall   = sc;
    RegWriteM = rw;
    MemtoRegM = m2r;
    ALUOutM   = alu;
    RD        = rd;
    WriteRegM = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string n);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check({n, "_valid"},    32'(sys_valid),    32'h0);
    check({n, "_halted"},   32'(halted),       32'h0);
    check({n, "_busy"},     32'(syscall_busy), 32'h0);
    check({n, "_regwrite"}, 32'(RegWriteW),    32'h0);
    check({n, "_writereg"}, 32'(WriteRegW),    32'h0);
    check({n, "_result"},   ResultW,           32'h0);
    check({n, "_code"},     sys_code,          32'h0);
    check({n, "_arg"},      sys_arg,           32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    drive_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    StallW = 1'b0; FlushW = 1'b0; v0_in = 32'h0; a0_in = 32'h0; sys_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_regwrite", 32'(RegWriteW),    32'h0);
    check("rst_result",   ResultW,           32'h0);
    check("rst_valid",    32'(sys_valid),    32'h0);
    check("rst_busy",     32'(syscall_busy), 32'h0);
    check("rst_halted",   32'(halted),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ALU and memory load paths, then a 3-cycle stall holding DEADBEEF
    drive_m(1'b0, 1'b1, 1'b0, 32'h5, 32'h1111, 5'd8);
    exp_wb("load_alu", 1'b1, 5'd8, 32'h5);
    exp_sys("load_sys", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive_m(1'b0, 1'b1, 1'b1, 32'h7, 32'hDEAD_BEEF, 5'd3);
    exp_wb("load_mem", 1'b1, 5'd3, 32'hDEAD_BEEF);
    step();
    StallW = 1'b1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h9, 32'h1234, 5'd4);
    for (int i = 0; i < 3; i++) begin
      exp_wb("stall_hold", 1'b1, 5'd3, 32'hDEAD_BEEF);
      step();
    end
    StallW = 1'b0;
    exp_wb("stall_release", 1'b1, 5'd4, 32'h9);
    step();

    // Flush beats stall: bubble clears write enable, data fields unchanged
    FlushW = 1'b1; StallW = 1'b1;
    drive_m(1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd5);
    exp_wb("flush_wins", 1'b0, 5'd4, 32'h9);
    step();
    FlushW = 1'b0; StallW = 1'b0;

    // Print syscall held 4 cycles (flush in the middle), then ready under stall
    drive_m(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd0);
    v0_in = 32'd1; a0_in = 32'd42;
    exp_wb("sc_enter", 1'b0, 5'd0, 32'h100);
    exp_sys("sc_enter", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive_m(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 5'd9);
    exp_sys("sc_req", 1'b1, 32'd1, 32'd42, 1'b1, 1'b0);
    exp_wb("sc_req_hold", 1'b0, 5'd0, 32'h100);
    step();
    v0_in = 32'd5; a0_in = 32'd99; FlushW = 1'b1;
    exp_sys("sc_flush", 1'b1, 32'd1, 32'd42, 1'b1, 1'b0);
    exp_wb("sc_flush", 1'b0, 5'd0, 32'h100);
    step();
    FlushW = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_sys("sc_wait", 1'b1, 32'd1, 32'd42, 1'b1, 1'b0);
      step();
    end
    sys_ready = 1'b1; StallW = 1'b1;
    exp_sys("sc_done", 1'b0, 32'd1, 32'd42, 1'b0, 1'b0);
    exp_wb("sc_bubble", 1'b0, 5'd0, 32'h100);
    step();
    StallW = 1'b0;
    exp_wb("sc_next", 1'b1, 5'd9, 32'h77);
    exp_sys("ready_ignored", 1'b0, 32'd1, 32'd42, 1'b0, 1'b0);
    step();
    sys_ready = 1'b0;

    // Immediate-ready syscall: handshake bubble must prevent a retrigger
    drive_m(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 5'd0);
    v0_in = 32'd11; a0_in = 32'hABCD;
    exp_sys("sc2_enter", 1'b0, 32'd1, 32'd42, 1'b1, 1'b0);
    step();
    drive_m(1'b0, 1'b1, 1'b1, 32'h0, 32'hCAFE, 5'd7);
    sys_ready = 1'b1;
    exp_sys("sc2_req", 1'b1, 32'd11, 32'hABCD, 1'b1, 1'b0);
    step();
    exp_sys("sc2_done", 1'b0, 32'd11, 32'hABCD, 1'b0, 1'b0);
    exp_wb("sc2_bubble", 1'b0, 5'd0, 32'h180);
    step();
    sys_ready = 1'b0;
    exp_wb("sc2_next", 1'b1, 5'd7, 32'hCAFE);
    exp_sys("sc2_idle", 1'b0, 32'd11, 32'hABCD, 1'b0, 1'b0);
    step();

    // Exit syscall: halt, write enable gated off, register frozen even on flush
    drive_m(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd0);
    v0_in = 32'd10;
    exp_wb("exit_enter", 1'b1, 5'd0, 32'h200);
    exp_sys("exit_enter", 1'b0, 32'd11, 32'hABCD, 1'b1, 1'b0);
    step();
    drive_m(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 5'd12);
    for (int i = 0; i < 3; i++) begin
      FlushW = (i == 2);
      exp_sys("halted", 1'b0, 32'd11, 32'hABCD, 1'b1, 1'b1);
      exp_wb("halt_frozen", 1'b0, 5'd0, 32'h200);
      step();
    end
    FlushW = 1'b0;
    pulse_reset("rst_halt");

    // Reach SYS_REQ again, then reset asynchronously between edges
    drive_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    v0_in = 32'd4; a0_in = 32'd7;
    exp_sys("rst_sc_enter", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    exp_sys("rst_sc_req", 1'b1, 32'd4, 32'd7, 1'b1, 1'b0);
    step();
    pulse_reset("rst_sysreq");
    exp_sys("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    repeat (3) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
